// File: rtl/nco_out_serializer_if.sv
// Off-chip nibble pad bus between the NCO output serializer and the
// external receiver.
//
// Signals:
//   Stb  - nibble valid on Dnib (driven by the serializer)
//   Frm  - high with the first (MSB) nibble of each sample
//   Dnib - nibble data, NW bits wide
//   Rdy  - receiver ready for the current nibble (driven by the receiver)
//
// Modports:
//   master - serializer side: drives Stb/Frm/Dnib, samples Rdy
//   slave  - receiver side: samples Stb/Frm/Dnib, drives Rdy
interface nco_out_serializer_if #(
  parameter int NW = 4
) ();

  logic          Stb;
  logic          Frm;
  logic [NW-1:0] Dnib;
  logic          Rdy;

  modport master (
    output Stb,
    output Frm,
    output Dnib,
    input  Rdy
  );

  modport slave (
    input  Stb,
    input  Frm,
    input  Dnib,
    output Rdy
  );

endinterface

// File: rtl/nco_out_serializer.sv
// NCO output serializer.
//
// Takes the 12-bit Dout/Vld sample stream of the NCO output terminal,
// keeps one of every Dec+1 valid samples, buffers the kept samples in a
// DEPTH-entry FIFO and ships each one off-chip as NPK nibbles of NW bits,
// MSB nibble first, over a strobe/frame/ready pad bus.
//
// Ports:
//   clk   - system clock, rising edge
//   rstn  - asynchronous active-low reset
//   Vld   - sample valid from the NCO output terminal
//   Din   - sample data (DW bits)
//   Dec   - decimation: keep 1 of every Dec+1 valid samples
//   Clr   - synchronous clear of Ovf
//   pad   - nibble pad bus (Stb/Frm/Dnib out, Rdy in), master side
//   Ovf   - sticky overflow: an accepted sample was dropped on a full FIFO
//   Lvl   - FIFO occupancy, 0..DEPTH
module nco_out_serializer #(
  parameter  int DW    = 12,
  parameter  int NW    = 4,
  parameter  int NPK   = 3,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Vld,
  input  logic [DW-1:0]       Din,
  input  logic [3:0]          Dec,
  input  logic                Clr,
  nco_out_serializer_if.master pad,
  output logic                Ovf,
  output logic [AW:0]         Lvl
);

  localparam int              IW       = (NPK > 1) ? $clog2(NPK) : 1;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NPK - 1);
  localparam logic [AW:0]     LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   lvl;
  logic [3:0]    dcnt;
  logic          ovf;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [DW-1:0] sreg;
  logic [DW-1:0] sreg_n;
  logic          stb;
  logic          stb_n;
  logic          frm;
  logic          frm_n;
  logic [NW-1:0] dnib;
  logic [NW-1:0] dnib_n;

  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  logic [DW-1:0] head;

  // Nibble i of a sample, counted from the MSB end.
  function automatic logic [NW-1:0] nib_of(input logic [DW-1:0] s,
                                           input logic [IW-1:0] i);
    logic [DW-1:0] t;
    t = s << (int'(i) * NW);
    return t[DW-1 -: NW];
  endfunction

  assign head   = mem[rptr];
  assign accept = Vld && (dcnt == 4'd0);
  // Full-check uses the pre-edge level, so a pop on the same edge never
  // makes room for a push into a full FIFO.
  assign push   = accept && (lvl != LVL_FULL);
  assign drop   = accept && (lvl == LVL_FULL);

  // The >= compare returns dcnt to 0 even if Dec was lowered below the
  // current count, so a shrinking ratio can never stall acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt <= 4'd0;
    end else if (Vld) begin
      if (dcnt >= Dec) begin
        dcnt <= 4'd0;
      end else begin
        dcnt <= dcnt + 4'd1;
      end
    end
  end

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= Din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  // A drop on the same edge as Clr leaves the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (Clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      sreg  <= '0;
      stb   <= 1'b0;
      frm   <= 1'b0;
      dnib  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      sreg  <= sreg_n;
      stb   <= stb_n;
      frm   <= frm_n;
      dnib  <= dnib_n;
    end
  end

  // Next-state logic also computes the next registered pad values, so the
  // pad outputs change only on edges. Without a transfer everything holds,
  // which keeps Stb/Frm/Dnib stable under backpressure.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sreg_n  = sreg;
    stb_n   = stb;
    frm_n   = frm;
    dnib_n  = dnib;
    pop     = 1'b0;

    case (state)
      IDLE: begin
        if (lvl != '0) begin
          pop     = 1'b1;
          sreg_n  = head;
          idx_n   = '0;
          state_n = SEND;
          stb_n   = 1'b1;
          frm_n   = 1'b1;
          dnib_n  = nib_of(head, '0);
        end else begin
          stb_n = 1'b0;
          frm_n = 1'b0;
        end
      end

      SEND: begin
        if (pad.Rdy) begin
          if (idx != IDX_LAST) begin
            idx_n  = idx + 1'b1;
            frm_n  = 1'b0;
            dnib_n = nib_of(sreg, idx + 1'b1);
          end else if (lvl != '0) begin
            // Back-to-back: next sample's MSB nibble follows immediately.
            pop    = 1'b1;
            sreg_n = head;
            idx_n  = '0;
            stb_n  = 1'b1;
            frm_n  = 1'b1;
            dnib_n = nib_of(head, '0);
          end else begin
            state_n = IDLE;
            stb_n   = 1'b0;
            frm_n   = 1'b0;
          end
        end
      end

      default: begin
        state_n = IDLE;
        stb_n   = 1'b0;
        frm_n   = 1'b0;
      end
    endcase
  end

  assign pad.Stb  = stb;
  assign pad.Frm  = frm;
  assign pad.Dnib = dnib;
  assign Ovf      = ovf;
  assign Lvl      = lvl;

endmodule
